// File: rtl/enigma_rotor_stepper_if.sv
// rtl/enigma_rotor_stepper_if.sv - keypress/load request and rotor position bus
// master drives keys and initial positions; slave reports positions and the cipher pulse.
interface enigma_rotor_stepper_if;
   logic       load_en;
   logic [4:0] init_l;
   logic [4:0] init_m;
   logic [4:0] init_r;
   logic       key_valid;
   logic       ready;
   logic [4:0] pos_l;
   logic [4:0] pos_m;
   logic [4:0] pos_r;
   logic       cipher_go;
   logic [1:0] state_dbg;

   modport master (
      output load_en, init_l, init_m, init_r, key_valid,
      input  ready, pos_l, pos_m, pos_r, cipher_go, state_dbg
   );

   modport slave (
      input  load_en, init_l, init_m, init_r, key_valid,
      output ready, pos_l, pos_m, pos_r, cipher_go, state_dbg
   );
endinterface

// File: rtl/enigma_rotor_stepper.sv
// rtl/enigma_rotor_stepper.sv - three-rotor Enigma stepping sequencer with double step
// One keypress: STEP updates the rotors, GO pulses cipher_go once they are stable.
module enigma_rotor_stepper #(
   parameter logic [4:0] NOTCH_R     = 5'd21,
   parameter logic [4:0] NOTCH_M     = 5'd4,
   parameter bit         DOUBLE_STEP = 1'b1
) (
   input  logic                  clk,
   input  logic                  resetn,
   enigma_rotor_stepper_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      STEP = 2'd1,
      GO   = 2'd2,
      LOAD = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [4:0] pos_l_q, pos_m_q, pos_r_q;
   logic       cipher_go_q;
   logic       step_m, step_l;

   function automatic logic [4:0] inc(input logic [4:0] x);
      return (x >= 5'd25) ? 5'd0 : x + 5'd1;
   endfunction

   function automatic logic [4:0] clamp(input logic [4:0] x);
      return (x > 5'd25) ? 5'd0 : x;
   endfunction

   // The middle rotor also steps itself when sitting on its own notch (double step).
   assign step_m = (pos_r_q == NOTCH_R) | (DOUBLE_STEP & (pos_m_q == NOTCH_M));
   assign step_l = (pos_m_q == NOTCH_M);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = IDLE;
      case (state_q)
         IDLE: begin
            if (bus.load_en) begin
               state_d = LOAD;
            end else if (bus.key_valid) begin
               state_d = STEP;
            end else begin
               state_d = IDLE;
            end
         end
         STEP:    state_d = GO;
         GO:      state_d = IDLE;
         LOAD:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pos_l_q     <= 5'd0;
         pos_m_q     <= 5'd0;
         pos_r_q     <= 5'd0;
         cipher_go_q <= 1'b0;
      end else begin
         cipher_go_q <= (state_q == STEP);
         case (state_q)
            LOAD: begin
               pos_l_q <= clamp(bus.init_l);
               pos_m_q <= clamp(bus.init_m);
               pos_r_q <= clamp(bus.init_r);
            end
            STEP: begin
               pos_r_q <= inc(pos_r_q);
               pos_m_q <= step_m ? inc(pos_m_q) : pos_m_q;
               pos_l_q <= step_l ? inc(pos_l_q) : pos_l_q;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.ready     = (state_q == IDLE);
   assign bus.state_dbg = state_q;
   assign bus.pos_l     = pos_l_q;
   assign bus.pos_m     = pos_m_q;
   assign bus.pos_r     = pos_r_q;
   assign bus.cipher_go = cipher_go_q;

endmodule
